// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the pipeline hazard controller
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

    // A source operand conflicts only if the instruction actually reads it.
    function automatic logic src_match(input logic uses,
                                       input logic [REG_AW_DEF-1:0] rs,
                                       input logic [REG_AW_DEF-1:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// rtl/hazard_ctrl_unit_if.sv - ID-stage hazard inputs and pipeline control outputs
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              branch_taken;
    logic              mem_busy;
    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              pipe_freeze;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_mem_read, ex_rd, branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               pipe_freeze, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_mem_read, ex_rd, branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               pipe_freeze, stall_cycles
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter for performance statistics
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use stall, branch flush and memory freeze control
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_unit_if.slave hz_if
);

    if (LOAD_LAT < 1 || LOAD_LAT > 8) begin : g_bad_load_lat
        $fatal(1, "hazard_ctrl_unit: LOAD_LAT must be in 1..8");
    end

    hz_state_t  state, state_n;
    logic [2:0] rem, rem_n;
    logic       hz;
    logic       pc_write_c, flush_c, bubble_c, freeze_c;
    logic       count_inc;

    // Load in EX writes a register that the ID instruction really reads.
    always_comb begin
        hz = hz_if.id_valid && hz_if.ex_mem_read && (hz_if.ex_rd != '0) &&
             (src_match(hz_if.id_uses_rs1, hz_if.id_rs1, hz_if.ex_rd) ||
              src_match(hz_if.id_uses_rs2, hz_if.id_rs2, hz_if.ex_rd));
    end

    // Prioritised control decode: reset, memory freeze, branch flush, ongoing stall, new hazard.
    always_comb begin
        pc_write_c = 1'b1;
        flush_c    = 1'b0;
        bubble_c   = 1'b0;
        freeze_c   = 1'b0;
        state_n    = state;
        rem_n      = rem;
        if (rst) begin
            state_n = IDLE;
            rem_n   = 3'd0;
        end else if (hz_if.mem_busy) begin
            pc_write_c = 1'b0;
            freeze_c   = 1'b1;
        end else if (hz_if.branch_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            state_n  = IDLE;
            rem_n    = 3'd0;
        end else if (state == LU_STALL) begin
            pc_write_c = 1'b0;
            bubble_c   = 1'b1;
            rem_n      = rem - 3'd1;
            if (rem == 3'd1) begin
                state_n = IDLE;
            end
        end else if (hz) begin
            pc_write_c = 1'b0;
            bubble_c   = 1'b1;
            if (LOAD_LAT > 1) begin
                state_n = LU_STALL;
                rem_n   = 3'(LOAD_LAT - 1);
            end
        end
    end

    // Stall FSM state and remaining-bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= 3'd0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
        end
    end

    // Only genuine load-use bubbles are counted; branch squashes are not.
    always_comb begin
        count_inc = bubble_c && !hz_if.branch_taken && !hz_if.mem_busy;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (count_inc),
        .cnt (hz_if.stall_cycles)
    );

    // Drive the pipeline control outputs.
    always_comb begin
        hz_if.pc_write     = pc_write_c;
        hz_if.if_id_write  = pc_write_c;
        hz_if.if_id_flush  = flush_c;
        hz_if.id_ex_bubble = bubble_c;
        hz_if.pipe_freeze  = freeze_c;
    end

endmodule
